// File: rtl/multicycle_controller.sv
// Control FSM for a shared-resource (multicycle) RV32I datapath.
// Sequences lw, sw, R-type, I-type ALU, beq and jal over a single ALU and a
// unified instruction/data memory. Memory accesses are stretched by mem_ready.
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pcWrite,
    output logic               adrSrc,
    output logic               memWrite,
    output logic               irWrite,
    output logic               regWrite,
    output logic [1:0]         resultSrc,
    output logic [1:0]         aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [1:0]         immSrc,
    output logic [1:0]         aluOp,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEMADR   = STATE_W'(2),
        S_MEMREAD  = STATE_W'(3),
        S_MEMWB    = STATE_W'(4),
        S_MEMWRITE = STATE_W'(5),
        S_EXECUTER = STATE_W'(6),
        S_ALUWB    = STATE_W'(7),
        S_EXECUTEI = STATE_W'(8),
        S_JAL      = STATE_W'(9),
        S_BEQ      = STATE_W'(10)
    } state_e;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_e state_q, state_d;

    // Ungated per-state strobes; the write enables are masked by rst_n below.
    logic pc_update;
    logic branch;
    logic mem_write_c;
    logic ir_write_c;
    logic reg_write_c;
    logic illegal_c;

    // State register: any reset, even mid-instruction, returns to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples the pre-edge values, independent of block ordering.
            state_q <= state_d;
        end
    end

    // Next-state decode and Moore outputs for the current state.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        pc_update   = 1'b0;
        branch      = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        illegal_c   = 1'b0;
        adrSrc      = 1'b0;
        resultSrc   = 2'b00;
        aluSrcA     = 2'b00;
        aluSrcB     = 2'b00;
        aluOp       = 2'b00;

        case (state_q)
            S_FETCH: begin
                aluSrcB    = 2'b10;
                resultSrc  = 2'b10;
                ir_write_c = mem_ready;
                pc_update  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adrSrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWRITE: begin
                adrSrc      = 1'b1;
                mem_write_c = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_MEMWB: begin
                resultSrc   = 2'b01;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_EXECUTER: begin
                aluSrcA = 2'b10;
                aluOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                aluOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                aluSrcA   = 2'b01;
                aluSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                aluSrcA = 2'b10;
                aluOp   = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (op)
            OP_SW:   immSrc = 2'b01;
            OP_BEQ:  immSrc = 2'b10;
            OP_JAL:  immSrc = 2'b11;
            default: immSrc = 2'b00;
        endcase
    end

    // Write enables are masked by rst_n directly so nothing is written while
    // reset is held, even though FETCH would otherwise raise irWrite/pcWrite.
    assign pcWrite  = rst_n & (pc_update | (branch & zero));
    assign irWrite  = rst_n & ir_write_c;
    assign regWrite = rst_n & reg_write_c;
    assign memWrite = rst_n & mem_write_c;
    assign illegal  = rst_n & illegal_c;
    assign state    = state_q;

endmodule
